uart_boot_loader: RTL

Upstream program loader for the single-cycle core. It receives a framed program image over UART and writes it word-by-word into port B of the instruction BRAM, which port A of the core fetches from using pc_address[14:2]. The core is held in reset until a complete, checksum-valid image has been written.

---
 rtl/boot_pkg.sv | 26 ++
 rtl/uart_rx.sv | 101 ++++++++++
 rtl/uart_boot_loader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared constants for the UART program loader: sync byte, FSM encodings, bit timing.
package boot_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Frame FSM states
  localparam logic [2:0] S_SYNC = 3'd0;
  localparam logic [2:0] S_LEN0 = 3'd1;
  localparam logic [2:0] S_LEN1 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // Receiver states
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Clocks per UART bit, integer-truncated
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, glitch-rejecting start check.
module uart_rx import boot_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_ferr_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  logic             sync1_q, sync2_q, prev_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic [7:0]       byte_q, byte_d;

  // State and datapath registers; synchronizer idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      byte_q  <= '0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      byte_q  <= byte_d;
    end
  end

  // Bit timing and sampling decisions
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    byte_d  = byte_q;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shreg_d = {sync2_q, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync2_q) begin
            valid_d = 1'b1;
            byte_d  = shreg_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_valid_o = valid_q;
  assign rx_byte_o  = byte_q;
  assign rx_ferr_o  = ferr_q;

endmodule

// File: rtl/uart_boot_loader.sv
// Receives a framed program image over UART and writes it into instruction BRAM port B.
module uart_boot_loader import boot_pkg::*; #(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned MAX_WORDS = 8192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned CW = 17;

  logic       rx_valid, rx_ferr;
  logic [7:0] rx_byte;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (uart_rx),
    .rx_valid_o (rx_valid),
    .rx_byte_o  (rx_byte),
    .rx_ferr_o  (rx_ferr)
  );

  logic [2:0]        state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       lo_q, lo_d;
  logic [7:0]        csum_q, csum_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              core_rst_q, core_rst_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic [15:0]       len_n_c;
  logic              last_word_c;

  // Frame FSM and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_SYNC;
      len_lo_q     <= '0;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_cnt_q   <= '0;
      lo_q         <= '0;
      csum_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      lo_q         <= lo_d;
      csum_q       <= csum_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rst_q   <= core_rst_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  // Frame parsing, word assembly and checksum
  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    byte_cnt_d   = byte_cnt_q;
    lo_d         = lo_q;
    csum_d       = csum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    core_rst_d   = core_rst_q;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;
    len_n_c      = {rx_byte, len_lo_q};
    last_word_c  = (CW'(word_idx_q) + CW'(1)) == CW'(len_q);
    case (state_q)
      S_SYNC: begin
        if (rx_valid && rx_byte == SYNC_BYTE) begin
          load_err_d = 1'b0;
          word_idx_d = '0;
          csum_d     = '0;
          byte_cnt_d = '0;
          state_d    = S_LEN0;
        end
      end
      S_LEN0: begin
        if (rx_ferr) begin
          load_err_d = 1'b1;
          state_d    = S_SYNC;
        end else if (rx_valid) begin
          len_lo_d = rx_byte;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (rx_ferr) begin
          load_err_d = 1'b1;
          state_d    = S_SYNC;
        end else if (rx_valid) begin
          if (len_n_c == 16'd0 || CW'(len_n_c) > CW'(MAX_WORDS)) begin
            load_err_d = 1'b1;
            state_d    = S_SYNC;
          end else begin
            len_d   = len_n_c;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_ferr) begin
          load_err_d = 1'b1;
          state_d    = S_SYNC;
        end else if (rx_valid) begin
          csum_d     = csum_q ^ rx_byte;
          byte_cnt_d = byte_cnt_q + 2'd1;
          lo_d       = {rx_byte, lo_q[23:8]};
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_idx_q;
            imem_wdata_d = {rx_byte, lo_q};
            word_idx_d   = word_idx_q + ADDR_W'(1);
            if (last_word_c) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (rx_ferr) begin
          load_err_d = 1'b1;
          state_d    = S_SYNC;
        end else if (rx_valid) begin
          if (rx_byte == csum_q) begin
            load_done_d = 1'b1;
            core_rst_d  = 1'b0;
            state_d     = S_DONE;
          end else begin
            load_err_d = 1'b1;
            state_d    = S_SYNC;
          end
        end
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_SYNC;
    endcase
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst   = core_rst_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule
